countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter DONE_TICKS, default 5, giving the number of tick_1hz pulses the block spends in DONE before it returns to IDLE.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port tick_1hz, input, 1 bit: one-clk-wide enable pulse, once per second.
REQ-005 The block SHALL have port load, input, 1 bit: level-sampled request to load a preset.
REQ-006 The block SHALL have port start, input, 1 bit: level-sampled request to begin or resume counting.
REQ-007 The block SHALL have port pause, input, 1 bit: level-sampled request to hold the count.
REQ-008 The block SHALL have ports set_mDecimal, set_mUnit, set_sDecimal and set_sUnit, each input, 4 bits: BCD preset value.
REQ-009 The block SHALL have ports mDecimal, mUnit, sDecimal and sUnit, each output, 4 bits: registered BCD time in MM:SS form.
REQ-010 The block SHALL have port actualState, output, 3 bits: registered FSM state code.
REQ-011 The block SHALL have port finish, output, 1 bit: registered flag, high exactly while the FSM is in DONE.

Function
REQ-012 The FSM SHALL use these states and actualState codes: IDLE=3'd0, LOADED=3'd1, RUNNING=3'd2, PAUSED=3'd3, DONE=3'd4; codes 5-7 SHALL never appear.
REQ-013 Input priority within one cycle SHALL be, highest first: reset, load, pause, start, tick_1hz.
REQ-014 When load=1 in IDLE, LOADED, PAUSED or DONE, the block SHALL capture the preset digits on that edge and enter LOADED; load SHALL be ignored in RUNNING.
REQ-015 Preset clamping SHALL apply on capture: any unit digit or mDecimal above 9 becomes 9; sDecimal above 5 becomes 5.
REQ-016 When start=1 in LOADED or PAUSED with a time other than 00:00, the block SHALL enter RUNNING on that edge; with time 00:00 it SHALL stay in its current state.
REQ-017 start SHALL be ignored in IDLE, RUNNING and DONE.
REQ-018 When pause=1 in RUNNING, the block SHALL enter PAUSED and the digits SHALL NOT change on that edge, even if tick_1hz=1.
REQ-019 In RUNNING, on each edge where tick_1hz=1, the time SHALL decrement by one second in BCD, updating the outputs on that same edge with zero added latency.
REQ-020 Decrement borrow chain: sUnit 0 becomes 9 and borrows; sDecimal 0 becomes 5 and borrows; mUnit 0 becomes 9 and borrows; mDecimal decrements by one.
REQ-021 The decrement from 00:01 SHALL produce 00:00 and enter DONE on the same edge, so finish is high in the next cycle.
REQ-022 In DONE, the digits SHALL hold 00:00 and an internal counter (width ceil(log2(DONE_TICKS+1))) SHALL count tick_1hz pulses.
REQ-023 On the DONE_TICKS-th pulse, the block SHALL enter IDLE and finish SHALL drop.
REQ-024 A load in DONE SHALL exit immediately to LOADED and clear the DONE counter.
REQ-025 In IDLE, the digits SHALL read 00:00.
REQ-026 tick_1hz SHALL have no effect in IDLE, LOADED or PAUSED.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-028 When reset=1 at a clk edge, the block SHALL set all digits to 0, actualState to 3'd0 (IDLE), finish to 0, and the DONE counter to 0.
REQ-029 Reset SHALL override every other input in any state, including mid-count and mid-DONE.

Verification
REQ-030 Load 01:00, start, then 1 tick -> 00:59, actualState=2; 59 more ticks -> 00:00, finish=1, actualState=4.
REQ-031 Load 10:00, start, then 1 tick -> 09:59, covering a borrow across all four digits.
REQ-032 Load preset digits F,A,7,C -> captured as 9,9,5,9.
REQ-033 In RUNNING at 00:30, assert pause and tick in the same cycle -> 00:30, actualState=3; start -> RUNNING, and the next tick gives 00:29.
REQ-034 Reach DONE with DONE_TICKS=5: 4 ticks keep finish=1; the 5th tick -> IDLE, finish=0. Separately, load in DONE -> LOADED.
REQ-035 Assert reset while RUNNING at 05:17 -> 00:00, actualState=0, finish=0; start while in IDLE -> no change.

Source files
------------

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/pause control and a timed DONE hold.
// All outputs come straight from registers; tick_1hz paces both counting and the DONE hold.
module countdown_timer #(
    parameter int DONE_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] set_mDecimal,
    input  logic [3:0] set_mUnit,
    input  logic [3:0] set_sDecimal,
    input  logic [3:0] set_sUnit,
    output logic [3:0] mDecimal,
    output logic [3:0] mUnit,
    output logic [3:0] sDecimal,
    output logic [3:0] sUnit,
    output logic [2:0] actualState,
    output logic       finish
);

    localparam int CW = $clog2(DONE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DONE_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOADED  = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_n;
    logic [3:0] md_n, mu_n, sd_n, su_n;
    logic [3:0] md_d, mu_d, sd_d, su_d;
    logic [CW-1:0] cnt, cnt_n;
    logic is_zero, last_sec, do_load;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    assign is_zero  = (mDecimal == 4'd0) && (mUnit == 4'd0)
                   && (sDecimal == 4'd0) && (sUnit == 4'd0);
    assign last_sec = (mDecimal == 4'd0) && (mUnit == 4'd0)
                   && (sDecimal == 4'd0) && (sUnit == 4'd1);
    assign do_load  = load && (state != RUNNING);

    // One-second BCD decrement with the borrow rippling up through the digits
    always_comb begin
        md_d = mDecimal;
        mu_d = mUnit;
        sd_d = sDecimal;
        su_d = sUnit;
        if (sUnit != 4'd0) begin
            su_d = sUnit - 4'd1;
        end else begin
            su_d = 4'd9;
            if (sDecimal != 4'd0) begin
                sd_d = sDecimal - 4'd1;
            end else begin
                sd_d = 4'd5;
                if (mUnit != 4'd0) begin
                    mu_d = mUnit - 4'd1;
                end else begin
                    mu_d = 4'd9;
                    md_d = mDecimal - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        md_n    = mDecimal;
        mu_n    = mUnit;
        sd_n    = sDecimal;
        su_n    = sUnit;
        cnt_n   = cnt;
        if (do_load) begin
            state_n = LOADED;
            md_n    = clamp(set_mDecimal, 4'd9);
            mu_n    = clamp(set_mUnit, 4'd9);
            sd_n    = clamp(set_sDecimal, 4'd5);
            su_n    = clamp(set_sUnit, 4'd9);
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    md_n = 4'd0;
                    mu_n = 4'd0;
                    sd_n = 4'd0;
                    su_n = 4'd0;
                end
                LOADED, PAUSED: begin
                    if (!pause && start && !is_zero)
                        state_n = RUNNING;
                end
                RUNNING: begin
                    if (pause) begin
                        state_n = PAUSED;
                    end else if (tick_1hz) begin
                        md_n = md_d;
                        mu_n = mu_d;
                        sd_n = sd_d;
                        su_n = su_d;
                        if (last_sec)
                            state_n = DONE;
                    end
                end
                DONE: begin
                    if (tick_1hz) begin
                        if (cnt == LAST) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    md_n    = 4'd0;
                    mu_n    = 4'd0;
                    sd_n    = 4'd0;
                    su_n    = 4'd0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mDecimal <= 4'd0;
            mUnit    <= 4'd0;
            sDecimal <= 4'd0;
            sUnit    <= 4'd0;
            cnt      <= '0;
            finish   <= 1'b0;
        end else begin
            state    <= state_n;
            mDecimal <= md_n;
            mUnit    <= mu_n;
            sDecimal <= sd_n;
            sUnit    <= su_n;
            cnt      <= cnt_n;
            finish   <= (state_n == DONE);
        end
    end

    assign actualState = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic,
// checked against a seconds-based reference model through a scoreboard queue.
module tb_countdown_timer;

    localparam int DT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] set_mDecimal = '0;
    logic [3:0] set_mUnit = '0;
    logic [3:0] set_sDecimal = '0;
    logic [3:0] set_sUnit = '0;
    logic [3:0] mDecimal, mUnit, sDecimal, sUnit;
    logic [2:0] actualState;
    logic       finish;

    countdown_timer #(.DONE_TICKS(DT)) dut (
        .clk(clk),
        .reset(reset),
        .tick_1hz(tick_1hz),
        .load(load),
        .start(start),
        .pause(pause),
        .set_mDecimal(set_mDecimal),
        .set_mUnit(set_mUnit),
        .set_sDecimal(set_sDecimal),
        .set_sUnit(set_sUnit),
        .mDecimal(mDecimal),
        .mUnit(mUnit),
        .sDecimal(sDecimal),
        .sUnit(sUnit),
        .actualState(actualState),
        .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] md;
        logic [3:0] mu;
        logic [3:0] sd;
        logic [3:0] su;
        logic [2:0] st;
        logic       fin;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    errors = 0;

    // Reference model: time held as total seconds, state as its code
    int m_state = 0;
    int m_secs = 0;
    int m_cnt = 0;

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    task automatic model_step(input logic r, tk, ld, st, ps, input logic [15:0] pre);
        if (r) begin
            m_state = 0;
            m_secs  = 0;
            m_cnt   = 0;
        end else if (ld && m_state != 2) begin
            m_secs = clampd(int'(pre[15:12]), 9) * 600
                   + clampd(int'(pre[11:8]), 9) * 60
                   + clampd(int'(pre[7:4]), 5) * 10
                   + clampd(int'(pre[3:0]), 9);
            m_state = 1;
            m_cnt   = 0;
        end else begin
            case (m_state)
                1, 3: if (!ps && st && m_secs != 0) m_state = 2;
                2: begin
                    if (ps) m_state = 3;
                    else if (tk) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) m_state = 4;
                    end
                end
                4: if (tk) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == DT) begin
                        m_state = 0;
                        m_cnt   = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.md  = 4'(m_secs / 600);
        o.mu  = 4'((m_secs / 60) % 10);
        o.sd  = 4'((m_secs % 60) / 10);
        o.su  = 4'(m_secs % 10);
        o.st  = 3'(m_state);
        o.fin = (m_state == 4);
        return o;
    endfunction

    task automatic drive(input logic r, tk, ld, st, ps,
                         input logic [15:0] pre, input string tag);
        @(negedge clk);
        reset    = r;
        tick_1hz = tk;
        load     = ld;
        start    = st;
        pause    = ps;
        {set_mDecimal, set_mUnit, set_sDecimal, set_sUnit} = pre;
        model_step(r, tk, ld, st, ps, pre);
        exp_q.push_back(model_obs());
        tag_q.push_back(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 16'h0, tag);
    endtask

    task automatic load_run(input logic [15:0] pre, input string tag);
        drive(0, 0, 1, 0, 0, pre, tag);
        drive(0, 0, 0, 1, 0, 16'h0, tag);
    endtask

    // Monitor: outputs settle one clock after each driven vector
    initial begin
        obs_t  e, a;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {mDecimal, mUnit, sDecimal, sUnit, actualState, finish};
                vectors++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %h%h:%h%h st=%0d fin=%b, want %h%h:%h%h st=%0d fin=%b",
                             t, a.md, a.mu, a.sd, a.su, a.st, a.fin,
                             e.md, e.mu, e.sd, e.su, e.st, e.fin);
                end
            end
        end
    end

    initial begin
        logic [15:0] pre;
        int bound;

        drive(1, 0, 0, 0, 0, 16'h0, "reset");
        drive(1, 1, 1, 1, 0, 16'h1234, "reset_override");
        drive(0, 0, 0, 1, 0, 16'h0, "idle_start");
        drive(0, 1, 0, 0, 0, 16'h0, "idle_tick");

        load_run(16'h0100, "run_0100");
        ticks(1, "tick_0059");
        ticks(58, "count_down");
        ticks(1, "reach_done");
        drive(0, 0, 0, 1, 1, 16'h0, "done_ignore");
        ticks(DT - 1, "done_hold");
        ticks(1, "done_exit");

        load_run(16'h0002, "run_0002");
        ticks(2, "done_again");
        ticks(2, "done_partial");
        drive(0, 0, 1, 0, 0, 16'h0003, "done_load");
        drive(0, 0, 0, 1, 0, 16'h0, "resume_0003");
        ticks(3, "done_third");
        ticks(DT, "done_cnt_cleared");

        load_run(16'h1000, "run_1000");
        ticks(1, "borrow_all");

        drive(0, 0, 1, 0, 0, 16'hFA7C, "clamp_load");
        drive(0, 0, 0, 0, 0, 16'h0, "clamp_hold");

        drive(0, 0, 1, 0, 0, 16'h0000, "load_zero");
        drive(0, 0, 0, 1, 0, 16'h0, "start_zero");

        load_run(16'h0031, "run_0031");
        ticks(1, "tick_0030");
        drive(0, 0, 1, 0, 0, 16'h0500, "run_load_ignored");
        drive(0, 1, 0, 0, 1, 16'h0, "pause_tick");
        drive(0, 1, 0, 0, 0, 16'h0, "paused_tick");
        drive(0, 0, 0, 1, 0, 16'h0, "resume");
        ticks(1, "tick_0029");

        load_run(16'h0518, "run_0518");
        ticks(1, "tick_0517");
        drive(1, 1, 0, 0, 0, 16'h0, "reset_running");
        drive(0, 0, 0, 1, 0, 16'h0, "idle_start_after_reset");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1, 0) == 1) pre = 16'($urandom);
            else pre = {12'h000, 4'($urandom)};
            drive($urandom_range(63, 0) == 0,
                  $urandom_range(1, 0) == 1,
                  $urandom_range(15, 0) == 0,
                  $urandom_range(3, 0) == 0,
                  $urandom_range(9, 0) == 0,
                  pre, "random");
        end

        bound = 0;
        while (exp_q.size() > 0 && bound < 10) begin
            @(posedge clk);
            bound++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
